// File: rtl/spi_host_pkg.sv
// Shared types and constants for the host-side SPI initiator that drives
// the RSA register-file slave.
package spi_host_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned RW_BIT  = 15;

  localparam logic [6:0] ADDR_STATUS  = 7'd0;
  localparam logic [6:0] ADDR_ACTIONS = 7'd1;
  localparam logic [6:0] ADDR_P       = 7'd2;
  localparam logic [6:0] ADDR_E       = 7'd3;
  localparam logic [6:0] ADDR_M       = 7'd4;
  localparam logic [6:0] ADDR_CONST   = 7'd5;
  localparam logic [6:0] ADDR_C       = 7'd6;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  // Byte 0 carries the R/W flag and address, byte 1 the write data (zero for reads).
  function automatic logic [FRAME_W-1:0] build_frame(input logic       write,
                                                     input logic [6:0] addr,
                                                     input logic [7:0] wdata);
    logic [FRAME_W-1:0] frame;
    frame         = {1'b0, addr, (write ? wdata : 8'h00)};
    frame[RW_BIT] = write;
    return frame;
  endfunction

endpackage

// File: rtl/spi_host_tick.sv
// Phase divider: tick_o marks the last clk cycle of each CLK_DIV-long SPI phase.
// Cleared whenever the owning FSM changes state so every phase starts aligned.
module spi_host_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_host_master.sv
// Host-side SPI mode-0 initiator: one 16-bit register read/write frame per
// accepted command, returning the byte sampled during the second frame byte.
module spi_host_master
  import spi_host_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned REG_W   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [REG_W-1:0]  cmd_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned BitCntW = $clog2(FRAME_W);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FRAME_W - 1);

  state_e state_q, state_d;
  logic   tick;
  logic   accept;

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [REG_W-1:0]   rx_q, rx_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [REG_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  assign accept = (state_q == StIdle) && cmd_valid;

  spi_host_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_d != state_q),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Every bit gets a full low phase after its high phase; the 16th low phase leads to HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StSetup;
      StSetup: if (tick) state_d = StHigh;
      StHigh:  if (tick) state_d = StLow;
      StLow:   if (tick) state_d = (bit_cnt_q == LastBit) ? StHold : StHigh;
      StHold:  if (tick) state_d = StGap;
      StGap:   if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      tx_d      = build_frame(cmd_write, 7'(cmd_addr), cmd_wdata);
      bit_cnt_d = '0;
    end
    // MISO is sampled late in the high phase to cover the slave's SCLK synchroniser.
    if (state_q == StHigh && tick) begin
      rx_d = {rx_q[REG_W-2:0], spi_miso};
      tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end
    if (state_q == StLow && tick && bit_cnt_q != LastBit) begin
      bit_cnt_d = bit_cnt_q + BitCntW'(1);
    end
    if (state_q == StHold && tick) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle) && !rst;
    busy      = (state_q != StIdle);
    spi_cs_n  = !(state_q inside {StSetup, StHigh, StLow, StHold});
    spi_clk   = (state_q == StHigh);
    spi_mosi  = (state_q inside {StSetup, StHigh, StLow}) ? tx_q[FRAME_W-1] : 1'b0;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: two instances (CLK_DIV 2 and 7), each with a mode-0
// slave model that records MOSI, drives MISO and measures SCLK phase lengths.
module tb_spi_host_master;
  import spi_host_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int unsigned CD = (g == 0) ? 2 : 7;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
    logic [7:0]  rsp_rdata;
    logic        spi_miso = 1'b0;
    logic [15:0] sl_out = '0, cap = '0;
    int          rises = 0, idx = 0, run = 0, rsp_cnt = 0;
    int          hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic        prev_clk = 1'b0, prev_cs = 1'b1;

    spi_host_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(CD)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .busy     (busy),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
    );

    // Slave model: captures MOSI on SCLK rise, shifts MISO on SCLK fall.
    always @(posedge clk) begin
      #1;
      if (rsp_valid) rsp_cnt++;
      if (!spi_cs_n && prev_cs) begin
        cap = '0; rises = 0; idx = 15; spi_miso = sl_out[15]; run = 1;
        hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
      end else if (!spi_cs_n) begin
        if (spi_clk && !prev_clk) begin
          cap = {cap[14:0], spi_mosi};
          if (rises > 0) begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
          rises++;
          run = 1;
        end else if (!spi_clk && prev_clk) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
          run = 1;
          idx--;
          if (idx >= 0) spi_miso = sl_out[idx];
        end else begin
          run++;
        end
      end
      prev_clk = spi_clk;
      prev_cs  = spi_cs_n;
    end
  end

  function automatic logic [15:0] exp_frame(input logic w, input logic [2:0] a,
                                            input logic [7:0] d);
    int v;
    v = (int'(w) * 32768) + (int'(a) * 256) + (w ? int'(d) : 0);
    return 16'(v);
  endfunction

  // Runs one command on the CLK_DIV=2 instance; cycle numbers count from the handshake cycle.
  task automatic frame0(input logic w, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] b1, output logic [7:0] rdata,
                        output int rsp_at, output int ready_at);
    int guard = 0;
    g_ch[0].sl_out = {8'($urandom), b1};
    while (!g_ch[0].cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    g_ch[0].cmd_write = w;
    g_ch[0].cmd_addr  = a;
    g_ch[0].cmd_wdata = d;
    g_ch[0].cmd_valid = 1'b1;
    rsp_at = -1; ready_at = -1; rdata = 8'h00;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) g_ch[0].cmd_valid = 1'b0;
      if (g_ch[0].rsp_valid && rsp_at < 0) begin
        rsp_at = n;
        rdata  = g_ch[0].rsp_rdata;
      end
      if (g_ch[0].cmd_ready) begin
        ready_at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if ({g_ch[0].spi_cs_n, g_ch[0].spi_clk, g_ch[0].spi_mosi, g_ch[0].busy,
         g_ch[0].rsp_valid, g_ch[0].cmd_ready} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got cs_n/clk/mosi/busy/rsp_valid/ready=%b expected 100000",
               {g_ch[0].spi_cs_n, g_ch[0].spi_clk, g_ch[0].spi_mosi, g_ch[0].busy,
                g_ch[0].rsp_valid, g_ch[0].cmd_ready});
    end
    checks++;
    if (g_ch[0].rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00", g_ch[0].rsp_rdata);
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
    if (g_ch[0].cmd_ready !== 1'b1 || g_ch[0].busy !== 1'b0 || g_ch[0].spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b cs_n=%b expected 1 0 1",
               g_ch[0].cmd_ready, g_ch[0].busy, g_ch[0].spi_cs_n);
    end
    checks++;
  endtask

  task automatic test_write();
    logic [7:0] rd, d, b1;
    logic [2:0] a;
    logic       w;
    int         rsp_at, ready_at;
    frame0(1'b1, 3'(ADDR_P), 8'hA5, 8'h5A, rd, rsp_at, ready_at);
    if (g_ch[0].cap !== 16'h82A5) begin
      errors++;
      $display("FAIL write_frame: got %h expected 82a5", g_ch[0].cap);
    end
    checks++;
    if (g_ch[0].rises != 16) begin
      errors++;
      $display("FAIL write_rises: got %0d expected 16", g_ch[0].rises);
    end
    checks++;
    if (rsp_at != 69 || ready_at != 71) begin
      errors++;
      $display("FAIL write_timing: got rsp=%0d ready=%0d expected 69 71", rsp_at, ready_at);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      w  = 1'($urandom);
      a  = 3'($urandom);
      d  = 8'($urandom);
      b1 = 8'($urandom);
      frame0(w, a, d, b1, rd, rsp_at, ready_at);
      if (g_ch[0].cap !== exp_frame(w, a, d) || rd !== b1 || rsp_at != 1 + 34 * 2) begin
        errors++;
        $display("FAIL random_cmd%0d: got frame=%h rdata=%h rsp=%0d expected %h %h %0d", i,
                 g_ch[0].cap, rd, rsp_at, exp_frame(w, a, d), b1, 1 + 34 * 2);
      end
      checks++;
    end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int         rsp_at, ready_at;
    frame0(1'b0, 3'(ADDR_C), 8'($urandom), 8'h3C, rd, rsp_at, ready_at);
    if (g_ch[0].cap !== 16'h0600) begin
      errors++;
      $display("FAIL read_frame: got %h expected 0600", g_ch[0].cap);
    end
    checks++;
    if (rd !== 8'h3C) begin
      errors++;
      $display("FAIL read_rdata: got %h expected 3c", rd);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] da;
    int         acc2 = -1, cs_hi = 0, done = -1;
    da = 8'($urandom);
    while (!g_ch[0].cmd_ready) @(negedge clk);
    g_ch[0].cmd_write = 1'b1;
    g_ch[0].cmd_addr  = 3'(ADDR_E);
    g_ch[0].cmd_wdata = da;
    g_ch[0].cmd_valid = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) begin
        g_ch[0].cmd_write = 1'b0;
        g_ch[0].cmd_addr  = 3'(ADDR_M);
      end
      if (g_ch[0].spi_cs_n) cs_hi++;
      if (g_ch[0].cmd_ready) begin
        acc2 = n;
        break;
      end
    end
    if (acc2 != 71) begin
      errors++;
      $display("FAIL b2b_accept: got cycle %0d expected 71", acc2);
    end
    checks++;
    if (g_ch[0].cap !== exp_frame(1'b1, 3'(ADDR_E), da)) begin
      errors++;
      $display("FAIL b2b_first_frame: got %h expected %h", g_ch[0].cap,
               exp_frame(1'b1, 3'(ADDR_E), da));
    end
    checks++;
    @(negedge clk);
    g_ch[0].cmd_valid = 1'b0;
    if (g_ch[0].spi_cs_n) cs_hi++;
    if (cs_hi < 2) begin
      errors++;
      $display("FAIL b2b_cs_gap: got %0d cycles expected at least 2", cs_hi);
    end
    checks++;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (g_ch[0].cmd_ready) begin
        done = n;
        break;
      end
    end
    if (done < 0 || g_ch[0].cap !== 16'h0400) begin
      errors++;
      $display("FAIL b2b_second_frame: got %h done=%0d expected 0400", g_ch[0].cap, done);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd, d;
    int         rsp_at, ready_at, cnt0, guard = 0;
    while (!g_ch[0].cmd_ready) @(negedge clk);
    g_ch[0].cmd_write = 1'b1;
    g_ch[0].cmd_addr  = 3'(ADDR_CONST);
    g_ch[0].cmd_wdata = 8'($urandom);
    g_ch[0].cmd_valid = 1'b1;
    @(negedge clk);
    g_ch[0].cmd_valid = 1'b0;
    while (g_ch[0].rises < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (g_ch[0].rises != 5) begin
      errors++;
      $display("FAIL abort_reach_rise5: got %0d rises expected 5", g_ch[0].rises);
    end
    checks++;
    cnt0 = g_ch[0].rsp_cnt;
    rst  = 1'b1;
    @(negedge clk);
    if (g_ch[0].spi_cs_n !== 1'b1 || g_ch[0].spi_clk !== 1'b0 || g_ch[0].busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got cs_n=%b clk=%b busy=%b expected 1 0 0",
               g_ch[0].spi_cs_n, g_ch[0].spi_clk, g_ch[0].busy);
    end
    checks++;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    if (g_ch[0].rsp_cnt != cnt0) begin
      errors++;
      $display("FAIL abort_no_rsp: got %0d pulses expected 0", g_ch[0].rsp_cnt - cnt0);
    end
    checks++;
    d = 8'($urandom);
    frame0(1'b1, 3'(ADDR_M), d, 8'h00, rd, rsp_at, ready_at);
    if (g_ch[0].cap !== exp_frame(1'b1, 3'(ADDR_M), d) || rsp_at != 69) begin
      errors++;
      $display("FAIL abort_recover: got frame=%h rsp=%0d expected %h 69", g_ch[0].cap, rsp_at,
               exp_frame(1'b1, 3'(ADDR_M), d));
    end
    checks++;
  endtask

  task automatic test_clk_div7();
    int rsp_at = -1, ready_at = -1;
    g_ch[1].sl_out = 16'($urandom);
    while (!g_ch[1].cmd_ready) @(negedge clk);
    g_ch[1].cmd_write = 1'b1;
    g_ch[1].cmd_addr  = 3'(ADDR_ACTIONS);
    g_ch[1].cmd_wdata = 8'h01;
    g_ch[1].cmd_valid = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) g_ch[1].cmd_valid = 1'b0;
      if (g_ch[1].rsp_valid && rsp_at < 0) rsp_at = n;
      if (g_ch[1].cmd_ready) begin
        ready_at = n;
        break;
      end
    end
    if (g_ch[1].cap !== 16'h8101 || g_ch[1].rises != 16) begin
      errors++;
      $display("FAIL div7_frame: got %h rises=%0d expected 8101 16", g_ch[1].cap, g_ch[1].rises);
    end
    checks++;
    if (g_ch[1].hi_min != 7 || g_ch[1].hi_max != 7 || g_ch[1].lo_min != 7 ||
        g_ch[1].lo_max != 7) begin
      errors++;
      $display("FAIL div7_phases: got hi %0d..%0d lo %0d..%0d expected 7..7 7..7",
               g_ch[1].hi_min, g_ch[1].hi_max, g_ch[1].lo_min, g_ch[1].lo_max);
    end
    checks++;
    if (rsp_at != 1 + 34 * 7 || ready_at != 1 + 35 * 7) begin
      errors++;
      $display("FAIL div7_timing: got rsp=%0d ready=%0d expected %0d %0d", rsp_at, ready_at,
               1 + 34 * 7, 1 + 35 * 7);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_clk_div7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
